// File: rtl/request_issue_pkg.sv
// rtl/request_issue_pkg.sv - shared state encoding and default sizing for the request issue unit
package request_issue_pkg;

  localparam int DEFAULT_ENTRY_WIDTH     = 32;
  localparam int DEFAULT_MAX_OUTSTANDING = 4;
  localparam int DEFAULT_CTR_WIDTH       = 3;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ISSUE       = 2'd1,
    CREDIT_WAIT = 2'd2,
    DRAIN       = 2'd3
  } state_e;

endpackage

// File: rtl/outstanding_counter.sv
// rtl/outstanding_counter.sv - saturating up/down count of issued requests awaiting a response
module outstanding_counter
  import request_issue_pkg::*;
#(
  parameter int MAX_COUNT = DEFAULT_MAX_OUTSTANDING,
  parameter int WIDTH     = DEFAULT_CTR_WIDTH
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             inc_in,
  input  logic             dec_in,
  output logic [WIDTH-1:0] count_out,
  output logic [WIDTH-1:0] count_next_out,
  output logic             underflow_out
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             dec_ok;

  // A decrement at zero is dropped; the caller flags it as a protocol error.
  assign dec_ok        = dec_in && (count_q != '0);
  assign underflow_out = dec_in && (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (inc_in && !dec_ok) begin
      if (count_q < MAX_VAL) begin
        count_d = count_q + WIDTH'(1);
      end
    end else if (dec_ok && !inc_in) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out      = count_q;
  assign count_next_out = count_d;

endmodule

// File: rtl/request_issue_unit.sv
// rtl/request_issue_unit.sv - single-slot issue stage between a request fifo and a credited downstream consumer
module request_issue_unit
  import request_issue_pkg::*;
#(
  parameter int SINGLE_ENTRY_WIDTH_IN_BITS    = DEFAULT_ENTRY_WIDTH,
  parameter int MAX_OUTSTANDING               = DEFAULT_MAX_OUTSTANDING,
  parameter int OUTSTANDING_CTR_WIDTH_IN_BITS = DEFAULT_CTR_WIDTH
) (
  input  logic                                     clk_in,
  input  logic                                     reset_in,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]    request_in,
  input  logic                                     request_valid_in,
  output logic                                     issue_ack_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]    request_out,
  output logic                                     request_valid_out,
  input  logic                                     issue_ack_in,
  input  logic                                     response_valid_in,
  input  logic                                     flush_in,
  output logic [OUTSTANDING_CTR_WIDTH_IN_BITS-1:0] outstanding_count_out,
  output logic                                     is_idle_out,
  output logic                                     protocol_error_out
);

  localparam int CW = OUTSTANDING_CTR_WIDTH_IN_BITS;
  localparam logic [CW:0] MAX_EXT = (CW+1)'(MAX_OUTSTANDING);

  state_e                                  state_q, state_d;
  logic                                    slot_valid_q, slot_valid_d;
  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]   slot_data_q, slot_data_d;
  logic                                    error_q, error_d;

  logic          down_xfer;
  logic          pop;
  logic          credit_ok;
  logic          underflow;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_next;
  logic [CW:0]   committed;

  // A flush discards the held entry, so it never counts as a transfer.
  assign down_xfer = slot_valid_q && issue_ack_in && !flush_in;

  outstanding_counter #(
    .MAX_COUNT (MAX_OUTSTANDING),
    .WIDTH     (CW)
  ) u_outstanding_counter (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .inc_in         (down_xfer),
    .dec_in         (response_valid_in),
    .count_out      (count_q),
    .count_next_out (count_next),
    .underflow_out  (underflow)
  );

  // Credits already committed after this edge: outstanding plus a slot that stays full.
  assign committed = {1'b0, count_next} + {{CW{1'b0}}, (slot_valid_q && !down_xfer)};
  assign credit_ok = committed < MAX_EXT;

  assign pop = request_valid_in && !flush_in && !reset_in && (state_q != DRAIN)
               && (!slot_valid_q || down_xfer) && credit_ok;

  always_comb begin
    state_d      = state_q;
    slot_valid_d = slot_valid_q;
    slot_data_d  = slot_data_q;
    error_d      = error_q | underflow;
    if (flush_in) begin
      state_d      = DRAIN;
      slot_valid_d = 1'b0;
      slot_data_d  = '0;
    end else if (state_q == DRAIN) begin
      if (count_q == '0) begin
        state_d = IDLE;
      end
    end else if (pop) begin
      state_d      = ISSUE;
      slot_valid_d = 1'b1;
      slot_data_d  = request_in;
    end else if (slot_valid_q && !down_xfer) begin
      state_d = ISSUE;
    end else begin
      slot_valid_d = 1'b0;
      state_d      = (request_valid_in && !credit_ok) ? CREDIT_WAIT : IDLE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q      <= IDLE;
      slot_valid_q <= 1'b0;
      slot_data_q  <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_valid_q <= slot_valid_d;
      slot_data_q  <= slot_data_d;
      error_q      <= error_d;
    end
  end

  assign issue_ack_out         = pop;
  assign request_out           = slot_data_q;
  assign request_valid_out     = slot_valid_q;
  assign outstanding_count_out = count_q;
  assign is_idle_out           = (state_q == IDLE) && (count_q == '0);
  assign protocol_error_out    = error_q;

endmodule

// File: doc/request_issue_unit.md
REQUEST_ISSUE_UNIT -- requirements
Module: request_issue_unit

Interface
REQ-001 SHALL have parameter SINGLE_ENTRY_WIDTH_IN_BITS, default 32, meaning the request payload width.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of issued requests awaiting a response.
REQ-003 SHALL have parameter OUTSTANDING_CTR_WIDTH_IN_BITS, default 3, meaning the counter width, at least clog2(MAX_OUTSTANDING+1).
REQ-004 SHALL have port clk_in  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_in  input  1  synchronous, active-high reset.
REQ-006 SHALL have port request_in  input  SINGLE_ENTRY_WIDTH_IN_BITS  head entry from the fifo_queue read port.
REQ-007 SHALL have port request_valid_in  input  1  fifo head entry valid.
REQ-008 SHALL have port issue_ack_out  output  1  pops the fifo head; drives the fifo_queue issue_ack_in.
REQ-009 SHALL have port request_out  output  SINGLE_ENTRY_WIDTH_IN_BITS  request to the downstream consumer.
REQ-010 SHALL have port request_valid_out  output  1  request_out valid.
REQ-011 SHALL have port issue_ack_in  input  1  downstream accepts request_out.
REQ-012 SHALL have port response_valid_in  input  1  one pulse per completed outstanding request.
REQ-013 SHALL have port flush_in  input  1  discard the held request and drain outstanding requests.
REQ-014 SHALL have port outstanding_count_out  output  OUTSTANDING_CTR_WIDTH_IN_BITS  current outstanding count.
REQ-015 SHALL have port is_idle_out  output  1  state IDLE and outstanding count 0.
REQ-016 SHALL have port protocol_error_out  output  1  sticky flag for a response received with count 0.

Function
REQ-017 SHALL define a transfer on either side as a cycle in which valid and ack are both 1 at the rising edge.
REQ-018 SHALL hold one entry in a registered holding slot; request_out and request_valid_out come from registers only.
REQ-019 SHALL assert issue_ack_out combinationally only when: request_valid_in=1, no flush is active, and the slot is empty or draining this cycle (request_valid_out&&issue_ack_in).
REQ-020 SHALL also require for issue_ack_out that outstanding count plus slot occupancy after this cycle is less than MAX_OUTSTANDING.
REQ-021 SHALL present an entry popped at edge N on request_out after edge N, giving a latency of 1 cycle; back-to-back transfers sustain 1 entry per cycle.
REQ-022 SHALL keep request_out and request_valid_out stable while request_valid_out=1 and issue_ack_in=0.
REQ-023 SHALL implement the FSM states IDLE (slot empty), ISSUE (slot full), CREDIT_WAIT (slot empty, credits exhausted, fifo non-empty) and DRAIN.
REQ-024 SHALL transition IDLE->ISSUE on a pop.
REQ-025 SHALL transition ISSUE->IDLE on a downstream transfer with no pop; ISSUE SHALL remain ISSUE on a simultaneous transfer and pop.
REQ-026 SHALL transition to CREDIT_WAIT when the slot empties at full credit; CREDIT_WAIT->ISSUE on a pop after a response frees credit.
REQ-027 SHALL, on flush_in=1 in any state, clear the slot and enter DRAIN, regardless of any simultaneous issue_ack_in.
REQ-028 SHALL hold issue_ack_out=0 and request_valid_out=0 in DRAIN, and leave DRAIN for IDLE when the count is 0 and flush_in=0.
REQ-029 SHALL increment the outstanding counter on a downstream transfer and decrement it on response_valid_in.
REQ-030 SHALL leave the counter unchanged when a downstream transfer and response_valid_in occur in the same cycle.
REQ-031 SHALL ignore response_valid_in when the count is 0 (no underflow) and set protocol_error_out.
REQ-032 SHALL never let the counter exceed MAX_OUTSTANDING.

Reset
REQ-033 SHALL, while reset_in=1 at an edge, go to state IDLE with slot empty, request_out=0, request_valid_out=0, count 0 and protocol_error_out=0.
REQ-034 SHALL hold issue_ack_out=0 during reset; reset mid-transfer discards the held entry and counts without any further handshake.
REQ-035 SHALL drive is_idle_out=1 in the first cycle after reset deasserts.

Structure
REQ-036 SHALL place the FSM state enum (IDLE, ISSUE, CREDIT_WAIT, DRAIN) and the default parameter constants in shared package request_issue_pkg.
REQ-037 SHALL implement the saturating up/down counter as sub-module outstanding_counter; all other logic stays in request_issue_unit.

Verification
REQ-038 SHALL cover single issue: fifo holds 0xA5A5_0001 with issue_ack_in=1 -> request_out=0xA5A5_0001 one cycle after the pop, count=1.
REQ-039 SHALL cover streaming: 8 entries, issue_ack_in=1, a response every cycle from cycle 2 -> one pop per cycle, in-order data, count at most 2.
REQ-040 SHALL cover credit limit: 6 entries with no responses -> exactly 4 issued, count=4, CREDIT_WAIT, issue_ack_out=0; one response -> 5th issued next cycle.
REQ-041 SHALL cover backpressure: issue_ack_in=0 for 5 cycles -> request_out stable, issue_ack_out=0 after the slot fills, no fifo entry lost.
REQ-042 SHALL cover flush: slot full and count=3, flush_in for 1 cycle -> slot cleared, DRAIN; 3 responses -> IDLE, is_idle_out=1.
REQ-043 SHALL cover error and reset: response at count 0 -> protocol_error_out=1 and count stays 0; reset_in mid-stream -> all outputs at reset values the next cycle.
